// File: rtl/fetch_stage_pkg.sv
// Shared constants for the WISC instruction-fetch stage.
//   - NOP / HALT encodings
//   - 2-bit fetch FSM state encoding
//   - instruction field slice helpers ([15:11] opcode, [10:8] rs, [7:5] rt)
package fetch_stage_pkg;

  localparam logic [15:0] NOP_WORD = 16'h0800;  // {5'b00001, 11'b0}
  localparam logic [4:0]  OP_HALT  = 5'b00000;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_FULL   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  function automatic logic [4:0] inst_opcode(input logic [15:0] inst);
    return inst[15:11];
  endfunction

  function automatic logic [2:0] inst_rs(input logic [15:0] inst);
    return inst[10:8];
  endfunction

  function automatic logic [2:0] inst_rt(input logic [15:0] inst);
    return inst[7:5];
  endfunction

endpackage

// File: rtl/fetch_stage_buf.sv
// fetch_buf: 32-bit holding register for the buffered instruction and its PC+2.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   load            capture inst_in / pc2_in
//   clear           zero the register (load wins if both are set)
//   inst_in, pc2_in next instruction word and its PC+2
//   inst_q, pc2_q   registered instruction word and PC+2
module fetch_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [15:0] inst_in,
  input  logic [15:0] pc2_in,
  output logic [15:0] inst_q,
  output logic [15:0] pc2_q
);

  logic [31:0] buf_d;
  logic [31:0] buf_q;

  always_comb begin
    // NOTE: hold value assigned first so every path writes buf_d; no latch.
    buf_d = buf_q;
    if (load) begin
      buf_d = {inst_in, pc2_in};
    end else if (clear) begin
      buf_d = '0;
    end
  end

  // NOTE: state uses non-blocking assignments; the register is reset (it is a
  // single word, not a memory array) so fetch_pc2 reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign inst_q = buf_q[31:16];
  assign pc2_q  = buf_q[15:0];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage WISC pipeline.
// Owns the PC, drives a stalling instruction memory and presents one buffered
// instruction per cycle to the hazard detector.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   pc_nop                        hazard stall: hold buffer and PC
//   redirect_valid, redirect_pc   downstream-resolved control transfer
//   imem_data/done/stall/err      instruction memory response
//   imem_rd, imem_addr            instruction memory request
//   fetch_inst, fetch_pc2         buffered instruction (NOP_INST when invalid) and its PC+2
//   fetch_valid                   buffer holds a real instruction
//   halted, err                   sticky HALT-delivered / fetch-fault flags
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_nop,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        imem_stall,
  input  logic        imem_err,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  output logic [15:0] fetch_inst,
  output logic [15:0] fetch_pc2,
  output logic        fetch_valid,
  output logic        halted,
  output logic        err
);

  fetch_state_e state_d, state_q;
  logic [15:0]  pc_d, pc_q;
  logic [15:0]  pend_pc_d, pend_pc_q;
  logic         kill_pend_d, kill_pend_q;
  logic         err_d, err_q;

  logic         rd_req;
  logic         buf_load;
  logic         buf_clear;
  logic         done;
  logic         fault;
  logic [15:0]  pc_plus2;
  logic [15:0]  inst_buf;
  logic [15:0]  pc2_buf;

  // A response flagged busy is not a completion; the request stays held.
  assign done     = imem_done & ~imem_stall;
  assign fault    = done & imem_err;
  assign pc_plus2 = pc_q + 16'd2;  // wraps at 16 bits by design

  fetch_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (buf_load),
    .clear   (buf_clear),
    .inst_in (imem_data),
    .pc2_in  (pc_plus2),
    .inst_q  (inst_buf),
    .pc2_q   (pc2_buf)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    kill_pend_d = kill_pend_q;
    err_d       = err_q;
    rd_req      = 1'b0;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;

    unique case (state_q)
      ST_FETCH, ST_WAIT: begin
        rd_req = 1'b1;
        if (fault) begin
          err_d       = 1'b1;
          kill_pend_d = 1'b0;
          buf_clear   = 1'b1;
          state_d     = ST_HALTED;
        end else if (done) begin
          // A redirect arriving with the data is newer than any pending one.
          if (redirect_valid) begin
            pc_d        = redirect_pc;
            kill_pend_d = 1'b0;
            state_d     = ST_FETCH;
          end else if (kill_pend_q) begin
            pc_d        = pend_pc_q;
            kill_pend_d = 1'b0;
            state_d     = ST_FETCH;
          end else begin
            buf_load = 1'b1;
            pc_d     = pc_plus2;
            state_d  = ST_FULL;
          end
        end else begin
          // Outstanding request cannot be cancelled; remember where to go.
          state_d = ST_WAIT;
          if (redirect_valid) begin
            pend_pc_d   = redirect_pc;
            kill_pend_d = 1'b1;
          end
        end
      end

      ST_FULL: begin
        if (redirect_valid) begin
          buf_clear = 1'b1;
          pc_d      = redirect_pc;
          state_d   = ST_FETCH;
        end else if (pc_nop) begin
          // hold buffer and PC, no request
        end else if (inst_opcode(inst_buf) == OP_HALT) begin
          buf_clear = 1'b1;
          state_d   = ST_HALTED;
        end else begin
          // Current instruction is consumed; next read overlaps it.
          rd_req = 1'b1;
          if (fault) begin
            err_d     = 1'b1;
            buf_clear = 1'b1;
            state_d   = ST_HALTED;
          end else if (done) begin
            buf_load = 1'b1;
            pc_d     = pc_plus2;
          end else begin
            buf_clear = 1'b1;
            state_d   = ST_WAIT;
          end
        end
      end

      ST_HALTED: begin
        // only reset leaves this state
      end

      default: state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      pend_pc_q   <= '0;
      kill_pend_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      kill_pend_q <= kill_pend_d;
      err_q       <= err_d;
    end
  end

  // Request is masked while reset is asserted even though state_q reads FETCH.
  assign imem_rd     = rd_req & rst;
  assign imem_addr   = pc_q;
  assign fetch_valid = (state_q == ST_FULL);
  assign fetch_inst  = fetch_valid ? inst_buf : NOP_INST;
  assign fetch_pc2   = pc2_buf;
  assign halted      = (state_q == ST_HALTED);
  assign err         = err_q;

endmodule
